// File: rtl/act_sched.sv
// Round-robin activation scheduler: N_REQ accumulators -> bound + ReLU, 2-cycle latency, 1 result/cycle.
// i_act_ready low stalls S2, then S1, then drops o_req_ready; define ACT_SCHED_SATCNT_EN to add o_sat_cnt.
module act_sched #(
  parameter int N_REQ  = 4,
  parameter int ACC_BW = 20,
  parameter int D_BW   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*ACC_BW-1:0]    i_req_data,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_act_valid,
  output logic [D_BW-1:0]            o_act_data,
  output logic [$clog2(N_REQ)-1:0]   o_act_id,
  input  logic                       i_act_ready,
`ifdef ACT_SCHED_SATCNT_EN
  output logic [15:0]                o_sat_cnt,
`endif
  output logic                       o_busy
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int IW1  = ID_W + 1;
  localparam logic signed [ACC_BW-1:0] POS_LIM = ACC_BW'((2 ** (D_BW - 1)) - 1);
  localparam logic signed [ACC_BW-1:0] NEG_LIM = ACC_BW'(-(2 ** (D_BW - 1)));

  logic [ID_W-1:0]          last_grant_q, last_grant_d;
  logic                     s1_vld_q, s1_vld_d;
  logic signed [ACC_BW-1:0] s1_dat_q, s1_dat_d;
  logic [ID_W-1:0]          s1_id_q, s1_id_d;
  logic                     s2_vld_q, s2_vld_d;
  logic [D_BW-1:0]          s2_dat_q, s2_dat_d;
  logic [ID_W-1:0]          s2_id_q, s2_id_d;

  logic                     win_vld;
  logic [ID_W-1:0]          win_idx;
  logic [ACC_BW-1:0]        win_dat;
  logic [IW1-1:0]           rr_sum;
  logic                     s2_adv;
  logic                     s1_take;
  logic                     xfer;
  logic                     clip_hi, clip_lo;
  logic [D_BW-1:0]          bounded;
  logic [D_BW-1:0]          relu_dat;

  // Search upward from last_grant+1 with wrap; first requester found wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_sum  = '0;
    for (int o = 1; o <= N_REQ; o++) begin
      rr_sum = {1'b0, last_grant_q} + IW1'(o);
      if (rr_sum >= IW1'(N_REQ)) begin
        rr_sum = rr_sum - IW1'(N_REQ);
      end
      if (!win_vld && i_req_valid[rr_sum[ID_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = rr_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    win_dat = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_idx == ID_W'(k)) begin
        win_dat = i_req_data[k*ACC_BW +: ACC_BW];
      end
    end
  end

  assign s2_adv  = s1_vld_q && (!s2_vld_q || i_act_ready);
  assign s1_take = !s1_vld_q || s2_adv;
  assign xfer    = win_vld && s1_take && !reset;

  always_comb begin
    o_req_ready = '0;
    if (xfer) begin
      o_req_ready = N_REQ'(1) << win_idx;
    end
  end

  // Bound to the signed D_BW range, then ReLU: net effect clamp(x, 0, POS_LIM).
  assign clip_hi = s1_dat_q > POS_LIM;
  assign clip_lo = s1_dat_q < NEG_LIM;

  always_comb begin
    if (clip_hi) begin
      bounded = POS_LIM[D_BW-1:0];
    end else if (clip_lo) begin
      bounded = NEG_LIM[D_BW-1:0];
    end else begin
      bounded = s1_dat_q[D_BW-1:0];
    end
    relu_dat = bounded[D_BW-1] ? '0 : bounded;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    s1_vld_d     = s1_vld_q;
    s1_dat_d     = s1_dat_q;
    s1_id_d      = s1_id_q;
    s2_vld_d     = s2_vld_q;
    s2_dat_d     = s2_dat_q;
    s2_id_d      = s2_id_q;

    if (s2_adv) begin
      s2_vld_d = 1'b1;
      s2_dat_d = relu_dat;
      s2_id_d  = s1_id_q;
    end else if (s2_vld_q && i_act_ready) begin
      s2_vld_d = 1'b0;
    end

    if (xfer) begin
      s1_vld_d     = 1'b1;
      s1_dat_d     = win_dat;
      s1_id_d      = win_idx;
      last_grant_d = win_idx;
    end else if (s2_adv) begin
      s1_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= ID_W'(N_REQ - 1);
      s1_vld_q     <= 1'b0;
      s1_dat_q     <= '0;
      s1_id_q      <= '0;
      s2_vld_q     <= 1'b0;
      s2_dat_q     <= '0;
      s2_id_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      s1_vld_q     <= s1_vld_d;
      s1_dat_q     <= s1_dat_d;
      s1_id_q      <= s1_id_d;
      s2_vld_q     <= s2_vld_d;
      s2_dat_q     <= s2_dat_d;
      s2_id_q      <= s2_id_d;
    end
  end

  assign o_act_valid = s2_vld_q;
  assign o_act_data  = s2_dat_q;
  assign o_act_id    = s2_id_q;
  assign o_busy      = s1_vld_q || s2_vld_q;

`ifdef ACT_SCHED_SATCNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Counts advances into S2 that were clipped by the bound stage (ReLU zeroing alone does not count).
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (s2_adv && (clip_hi || clip_lo) && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign o_sat_cnt = sat_cnt_q;
`endif

endmodule

// File: doc/act_sched.md
ACT_SCHED -- requirements
Module: act_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing the activation datapath (2..8).
REQ-002 SHALL have parameter ACC_BW, default 20: signed accumulator width per requester.
REQ-003 SHALL have parameter D_BW, default 8: signed activation output width (ACC_BW > D_BW).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_req_valid  input  N_REQ  per-requester data valid.
REQ-007 SHALL have port i_req_data  input  N_REQ*ACC_BW  packed accumulators; requester k occupies bits [k*ACC_BW +: ACC_BW].
REQ-008 SHALL have port o_req_ready  output  N_REQ  one-hot-or-zero accept strobe per requester.
REQ-009 SHALL have port o_act_valid  output  1  activation result valid.
REQ-010 SHALL have port o_act_data  output  D_BW  bounded, ReLU'd result.
REQ-011 SHALL have port o_act_id  output  clog2(N_REQ)  index of the originating requester.
REQ-012 SHALL have port i_act_ready  input  1  downstream accept.
REQ-013 SHALL have port o_busy  output  1  high when either pipeline stage holds data.

Function
REQ-014 SHALL implement two register stages: S1 (arbitrate + capture), S2 (bound + ReLU, output register); latency 2 cycles with no backpressure, throughput 1/cycle.
REQ-015 SHALL grant round-robin: winner is the first index with i_req_valid set, searching upward (with wrap) from last_grant+1.
REQ-016 SHALL assert o_req_ready[k] only for the winner, and only when S1 can accept (S1 empty, or S1 advancing into S2 this cycle); a transfer occurs when o_req_ready[k] && i_req_valid[k].
REQ-017 SHALL update last_grant only on a transfer; no transfer leaves it unchanged.
REQ-018 SHALL let S2 accept from S1 when S2 is empty or i_act_ready is high; an output transfer occurs when o_act_valid && i_act_ready.
REQ-019 SHALL hold o_act_valid, o_act_data and o_act_id stable while o_act_valid && !i_act_ready.
REQ-020 SHALL bound the signed ACC_BW value to the signed D_BW range: > 2^(D_BW-1)-1 -> 2^(D_BW-1)-1; < -2^(D_BW-1) -> -2^(D_BW-1); else truncate.
REQ-021 SHALL apply ReLU to the bounded value: sign bit set -> all-zero, else value unchanged; net result is clamp(x, 0, 2^(D_BW-1)-1).
REQ-022 SHALL, with S1 and S2 both full and i_act_ready low, drive o_req_ready to zero (no data loss, no overwrite).
REQ-023 SHALL, when S2 drains and S1 refills in the same cycle, sustain full throughput without a bubble.
REQ-024 SHALL ignore i_req_valid bits of non-granted requesters; i_req_data is sampled only on transfer.

Reset
REQ-025 SHALL, on reset, clear S1/S2 valid flags, set last_grant to N_REQ-1 (first grant favours index 0), and drive o_act_valid=0, o_act_data=0, o_act_id=0, o_req_ready=0, o_busy=0.
REQ-026 SHALL give reset asserted mid-operation priority over any transfer; in-flight data is discarded.

Configuration
REQ-027 SHALL, when macro ACT_SCHED_SATCNT_EN is defined, add output o_sat_cnt (16 bits, reset 0) incrementing by 1 on each S1->S2 advance whose value was clipped by REQ-020 (either direction), saturating at 0xFFFF.
REQ-028 SHALL, when ACT_SCHED_SATCNT_EN is undefined, omit o_sat_cnt and its logic entirely; all other behaviour identical.

Verification (N_REQ=4, ACC_BW=20, D_BW=8)
REQ-029 SHALL cover: req0 data 0x00050, i_act_ready=1 -> o_act_data=0x50, o_act_id=0 exactly 2 cycles after transfer.
REQ-030 SHALL cover: inputs 0x00200, 0xFFFF0, 0x80000, 0x0007F -> outputs 0x7F, 0x00, 0x00, 0x7F; SATCNT build o_sat_cnt=2.
REQ-031 SHALL cover: all four i_req_valid held high, i_act_ready=1 -> o_act_id sequence 0,1,2,3,0,1... with o_act_valid continuous.
REQ-032 SHALL cover: i_act_ready low 3 cycles with stream pending -> o_act_data/o_act_id stable, o_req_ready=0 once S1 full, no sample lost or duplicated after release.
REQ-033 SHALL cover: reset pulsed 1 cycle with both stages full -> next cycle o_act_valid=0, o_busy=0; first subsequent grant to index 0.
